// File: rtl/acc_cpu_sequencer.sv
// Fetch/decode/execute sequencer for the accumulator ALU: owns pc, instruction,
// operand and accumulator registers, and drives the instruction/data memory strobes.
module acc_cpu_sequencer #(
   parameter int DATA_SIZE   = 8,
   parameter int OPCODE_SIZE = 4,
   parameter int INSTR_SIZE  = 12,
   parameter int ADDR_SIZE   = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         run,
   output logic        [ADDR_SIZE-1:0]  imem_addr,
   output logic                         imem_rd_en,
   input  logic        [INSTR_SIZE-1:0] imem_rdata,
   output logic        [ADDR_SIZE-1:0]  dmem_addr,
   output logic                         dmem_rd_en,
   output logic                         dmem_wr_en,
   output logic        [DATA_SIZE-1:0]  dmem_wdata,
   input  logic        [DATA_SIZE-1:0]  dmem_rdata,
   output logic        [INSTR_SIZE-1:0] instr_reg,
   output logic signed [DATA_SIZE-1:0]  accumulator,
   output logic signed [DATA_SIZE-1:0]  from_mem_data,
   input  logic        [DATA_SIZE-1:0]  alu_out,
   input  logic                         we_alu,
   output logic                         zero,
   output logic                         halted
);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_MEMRD, S_MEMWAIT, S_EXEC, S_HALT
   } state_t;

   localparam logic [OPCODE_SIZE-1:0] OP_MEM_LO = OPCODE_SIZE'(1);
   localparam logic [OPCODE_SIZE-1:0] OP_MEM_HI = OPCODE_SIZE'(6);
   localparam logic [OPCODE_SIZE-1:0] OP_ALU_HI = OPCODE_SIZE'(11);
   localparam logic [OPCODE_SIZE-1:0] OP_JMP    = OPCODE_SIZE'(13);
   localparam logic [OPCODE_SIZE-1:0] OP_JZ     = OPCODE_SIZE'(14);
   localparam logic [OPCODE_SIZE-1:0] OP_HALT   = OPCODE_SIZE'(15);

   state_t                 state_q, state_d;
   logic [ADDR_SIZE-1:0]   pc_q, pc_d;
   logic [INSTR_SIZE-1:0]  ir_q, ir_d;
   logic [DATA_SIZE-1:0]   acc_q, acc_d;
   logic [DATA_SIZE-1:0]   mdr_q, mdr_d;
   logic [OPCODE_SIZE-1:0] ir_op, in_op;
   logic [ADDR_SIZE-1:0]   ir_addr;
   logic                   imem_rd, dmem_rd, dmem_wr;

   assign ir_op   = ir_q[INSTR_SIZE-1 -: OPCODE_SIZE];
   assign in_op   = imem_rdata[INSTR_SIZE-1 -: OPCODE_SIZE];
   assign ir_addr = ir_q[ADDR_SIZE-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         acc_q   <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         acc_q   <= acc_d;
         mdr_q   <= mdr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      acc_d   = acc_q;
      mdr_d   = mdr_q;
      imem_rd = 1'b0;
      dmem_rd = 1'b0;
      dmem_wr = 1'b0;
      case (state_q)
         S_FETCH: begin
            imem_rd = run;
            if (run) state_d = S_DECODE;
         end
         S_DECODE: begin
            ir_d = imem_rdata;
            pc_d = pc_q + ADDR_SIZE'(1);
            // Decode on the memory output so the operand fetch can start next cycle.
            if (in_op >= OP_MEM_LO && in_op <= OP_MEM_HI) state_d = S_MEMRD;
            else if (in_op == OP_HALT)                    state_d = S_HALT;
            else                                          state_d = S_EXEC;
         end
         S_MEMRD: begin
            dmem_rd = 1'b1;
            state_d = S_MEMWAIT;
         end
         S_MEMWAIT: begin
            mdr_d   = dmem_rdata;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            dmem_wr = we_alu;
            if (ir_op == OP_JMP || (ir_op == OP_JZ && acc_q == '0)) pc_d = ir_addr;
            if (ir_op >= OP_MEM_LO && ir_op <= OP_ALU_HI) acc_d = alu_out;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Strobes are gated by rst_n so an in-flight write is dropped the moment reset asserts.
   assign imem_rd_en    = imem_rd & rst_n;
   assign dmem_rd_en    = dmem_rd & rst_n;
   assign dmem_wr_en    = dmem_wr & rst_n;
   assign imem_addr     = pc_q;
   assign dmem_addr     = ir_addr;
   assign dmem_wdata    = acc_q;
   assign instr_reg     = ir_q;
   assign accumulator   = acc_q;
   assign from_mem_data = mdr_q;
   assign zero          = (acc_q == '0);
   assign halted        = (state_q == S_HALT);

endmodule

// File: tb/tb_acc_cpu_sequencer.sv
// Directed bench for acc_cpu_sequencer: two-instruction programs from a vector table,
// plus hand sequences for jumps, pc wrap, halt, run stall and reset during a store.
module tb_acc_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        run;
   logic [7:0]  imem_addr;
   logic        imem_rd_en;
   logic [11:0] imem_rdata;
   logic [7:0]  dmem_addr;
   logic        dmem_rd_en;
   logic        dmem_wr_en;
   logic [7:0]  dmem_wdata;
   logic [7:0]  dmem_rdata;
   logic [11:0] instr_reg;
   logic [7:0]  accumulator;
   logic [7:0]  from_mem_data;
   logic [7:0]  alu_out;
   logic        we_alu;
   logic        zero;
   logic        halted;

   acc_cpu_sequencer #(.DATA_SIZE(8), .OPCODE_SIZE(4), .INSTR_SIZE(12), .ADDR_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n), .run(run),
      .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
      .dmem_addr(dmem_addr), .dmem_rd_en(dmem_rd_en), .dmem_wr_en(dmem_wr_en),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .instr_reg(instr_reg), .accumulator(accumulator), .from_mem_data(from_mem_data),
      .alu_out(alu_out), .we_alu(we_alu), .zero(zero), .halted(halted)
   );

   always #5 clk = ~clk;

   logic [11:0] imem [256];
   logic [7:0]  dmem [256];
   logic        dm_clr = 1'b0, dm_ld = 1'b0;
   logic [7:0]  dm_ld_a = '0, dm_ld_v = '0;
   int          rd_cnt, wr_cnt, bad_rd;
   int          n_chk = 0, n_fail = 0;

   // ALU: 1 LD, 2 ADD, 3 SUB, A LDI, B ADDI, C ST; anything else passes acc through.
   always_comb begin
      alu_out = accumulator;
      we_alu  = 1'b0;
      case (instr_reg[11:8])
         4'h1: alu_out = from_mem_data;
         4'h2: alu_out = accumulator + from_mem_data;
         4'h3: alu_out = accumulator - from_mem_data;
         4'hA: alu_out = instr_reg[7:0];
         4'hB: alu_out = accumulator + instr_reg[7:0];
         4'hC: we_alu  = 1'b1;
         default: ;
      endcase
   end

   always @(posedge clk) if (imem_rd_en) imem_rdata <= imem[imem_addr];

   always @(posedge clk) begin
      if (dm_clr) begin
         for (int i = 0; i < 256; i++) dmem[i] <= '0;
         rd_cnt <= 0; wr_cnt <= 0; bad_rd <= 0;
      end else if (dm_ld) begin
         dmem[dm_ld_a] <= dm_ld_v;
      end else begin
         if (dmem_rd_en) begin
            dmem_rdata <= dmem[dmem_addr];
            rd_cnt <= rd_cnt + 1;
            if (dmem_wr_en) bad_rd <= bad_rd + 1;
         end
         if (dmem_wr_en) begin
            dmem[dmem_addr] <= dmem_wdata;
            wr_cnt <= wr_cnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic load_prog(input logic [11:0] i0, input logic [11:0] i1);
      for (int i = 0; i < 256; i++) imem[i] = 12'hF00;
      imem[0] = i0;
      imem[1] = i1;
   endtask

   // Leaves rst_n released, 1 time unit into the first FETCH cycle.
   task automatic reset_dut(input logic [7:0] da, input logic [7:0] dv);
      rst_n = 1'b0; run = 1'b1; dm_clr = 1'b1;
      @(negedge clk);
      dm_clr = 1'b0; dm_ld = 1'b1; dm_ld_a = da; dm_ld_v = dv;
      @(negedge clk);
      dm_ld = 1'b0; rst_n = 1'b1;
      #1;
   endtask

   task automatic wait_fetch(input logic [7:0] a, input int budget, output int n);
      n = 0;
      while (!(imem_rd_en && imem_addr == a) && n < budget) begin
         @(negedge clk); #1; n++;
      end
   endtask

   typedef struct {
      string       name;
      logic [11:0] i0, i1;
      logic [7:0]  dm_a, dm_v;
      int          cycles;
      logic [7:0]  acc;
      logic        zero;
      logic [7:0]  fmd;
      int          rd, wr;
      logic [7:0]  mem_a, mem_v;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int n;
      int strobes;
      vecs[0] = '{"ldi_addi",  12'hA7F, 12'hB01, 8'h10, 8'h00,  6, 8'h80, 1'b0, 8'h00, 0, 0, 8'h10, 8'h00};
      vecs[1] = '{"ld_sub",    12'h110, 12'h310, 8'h10, 8'h05, 10, 8'h00, 1'b1, 8'h05, 2, 0, 8'h10, 8'h05};
      vecs[2] = '{"ldi_st",    12'hA3C, 12'hC20, 8'h10, 8'h00,  6, 8'h3C, 1'b0, 8'h00, 0, 1, 8'h20, 8'h3C};
      vecs[3] = '{"ldi_add",   12'hA05, 12'h210, 8'h10, 8'hFD,  8, 8'h02, 1'b0, 8'hFD, 1, 0, 8'h10, 8'hFD};
      vecs[4] = '{"ldi_nop",   12'hA55, 12'h000, 8'h10, 8'h00,  6, 8'h55, 1'b0, 8'h00, 0, 0, 8'h10, 8'h00};
      vecs[5] = '{"wrap_zero", 12'hA80, 12'hB80, 8'h10, 8'h00,  6, 8'h00, 1'b1, 8'h00, 0, 0, 8'h10, 8'h00};

      // Reset held with run=1: everything quiet.
      load_prog(12'hA7F, 12'hB01);
      rst_n = 1'b0; run = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_strobes", {imem_rd_en, dmem_rd_en, dmem_wr_en, halted}, 4'b0000);
      chk("rst_regs", {imem_addr, instr_reg, accumulator, from_mem_data}, 36'h0);
      reset_dut(8'h10, 8'h00);
      chk("rst_first_fetch", {imem_rd_en, imem_addr}, {1'b1, 8'h00});

      foreach (vecs[k]) begin
         load_prog(vecs[k].i0, vecs[k].i1);
         reset_dut(vecs[k].dm_a, vecs[k].dm_v);
         wait_fetch(8'h02, 40, n);
         chk({vecs[k].name, "_cycles"}, n, vecs[k].cycles);
         chk({vecs[k].name, "_acc"}, accumulator, vecs[k].acc);
         chk({vecs[k].name, "_zero"}, zero, vecs[k].zero);
         chk({vecs[k].name, "_fmd"}, from_mem_data, vecs[k].fmd);
         chk({vecs[k].name, "_rd_cnt"}, rd_cnt, vecs[k].rd);
         chk({vecs[k].name, "_wr_cnt"}, wr_cnt, vecs[k].wr);
         chk({vecs[k].name, "_mem"}, dmem[vecs[k].mem_a], vecs[k].mem_v);
         chk({vecs[k].name, "_rd_wr_overlap"}, bad_rd, 0);
      end

      // JZ taken with acc=0.
      load_prog(12'hE40, 12'h000);
      reset_dut(8'h10, 8'h00);
      wait_fetch(8'h40, 20, n);
      chk("jz_taken_cycles", n, 3);

      // JZ not taken with acc=1: falls through to pc+1.
      load_prog(12'hA01, 12'hE40);
      reset_dut(8'h10, 8'h00);
      wait_fetch(8'h02, 20, n);
      chk("jz_not_taken_cycles", n, 6);

      // JMP to 0xFE, then sequential NOPs wrap the pc from 0xFF to 0x00.
      load_prog(12'hDFE, 12'h000);
      imem[8'hFE] = 12'h000;
      imem[8'hFF] = 12'h000;
      reset_dut(8'h10, 8'h00);
      wait_fetch(8'hFE, 20, n);
      chk("jmp_cycles", n, 3);
      wait_fetch(8'hFF, 20, n);
      chk("seq_to_ff_cycles", n, 3);
      wait_fetch(8'h00, 20, n);
      chk("pc_wrap_cycles", n, 3);

      // HALT: halted two cycles after fetch, then silent with run=1.
      load_prog(12'hF00, 12'h000);
      reset_dut(8'h10, 8'h00);
      repeat (2) begin @(negedge clk); #1; end
      chk("halt_latency", halted, 1'b1);
      strobes = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (imem_rd_en || dmem_rd_en || dmem_wr_en) strobes++;
      end
      chk("halt_no_strobes", strobes, 0);
      chk("halt_sticky", halted, 1'b1);

      // run dropped during DECODE: instruction finishes, stalls in next FETCH.
      load_prog(12'hA7F, 12'hB01);
      reset_dut(8'h10, 8'h00);
      @(negedge clk); run = 1'b0; #1;
      repeat (5) begin @(negedge clk); #1; end
      chk("stall_no_fetch", {imem_rd_en, imem_addr}, {1'b0, 8'h01});
      chk("stall_acc", accumulator, 8'h7F);
      run = 1'b1; #1;
      chk("stall_resume", {imem_rd_en, imem_addr}, {1'b1, 8'h01});

      // Reset asserted while the store is in EXEC.
      load_prog(12'hA3C, 12'hC20);
      reset_dut(8'h10, 8'h00);
      repeat (5) begin @(negedge clk); #1; end
      chk("st_wr_before_rst", {dmem_wr_en, dmem_addr, dmem_wdata}, {1'b1, 8'h20, 8'h3C});
      rst_n = 1'b0; #1;
      chk("st_wr_dropped", {dmem_wr_en, imem_addr, accumulator}, {1'b0, 8'h00, 8'h00});
      @(negedge clk); #1;
      chk("st_mem_untouched", dmem[8'h20], 8'h00);
      rst_n = 1'b1; #1;
      chk("st_restart_fetch", {imem_rd_en, imem_addr}, {1'b1, 8'h00});

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
